clk_time_set_ctrl: RTL and testbench
====================================

Name: clk_time_set_ctrl

Overview:
Mode controller and time-keeping sequencer for the Basys3 12-hour digital clock. Owns the BCD hh:mm time registers and the 1 Hz prescaler. Runs a RUN / SET_HOUR / SET_MIN state machine, driven by two debounced push buttons. Feeds the four BCD digits, the AM/PM flag and a per-digit blink mask to the seven-segment display driver.

Parameters:
TICKS_PER_SEC, 100_000_000, clk cycles per second (prescaler terminal count + 1)
BLINK_DIV, 25_000_000, clk cycles per half-period of the set-mode blink

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
btn_mode  in  1  mode button, debounced level, asynchronous to clk
btn_inc  in  1  increment button, debounced level, asynchronous to clk
digit1_min  out  4  minutes ones, BCD 0-9
digit2_min  out  4  minutes tens, BCD 0-5
digit3_hour  out  4  hours ones, BCD 0-9
digit4_hour  out  4  hours tens, 0 or 1
pm  out  1  1 = PM
setting  out  1  1 when state is not RUN
blink_mask  out  4  bit i = 1 blanks digit i+1 this cycle
sec_tick  out  1  one-cycle pulse per elapsed second (RUN only)

Behaviour:
- Reset (async, all registers): time 12:00 AM (digit4=1, digit3=2, digit2=0, digit1=0), pm=0, seconds=0, prescaler=0, state RUN, setting=0, blink_mask=0, sec_tick=0, blink counter and phase 0. Reset mid-set abandons edits.
- Buttons: 2-flop synchronizer, then rising-edge detect. Input rising at cycle N gives an internal pulse at N+2; the registered output changes at N+3. A held button produces exactly one event.
- Prescaler counts 0..TICKS_PER_SEC-1 in RUN only. At the terminal count: sec_tick=1 for that cycle and the prescaler returns to 0. Outside RUN, prescaler and seconds are held at 0.
- Seconds count 0..59. A tick at 59 gives seconds=0 plus a minute increment, in the same cycle.
- Minute increment (RUN): ones 9 -> 0 with carry to tens. 59 -> 00 with an hour increment.
- Hour increment: 09 -> 10, 10 -> 11, 11 -> 12 toggles pm, 12 -> 01. All other values do ones+1. Illegal hour values are unreachable.
- FSM transitions on a btn_mode event:
  - RUN -> SET_HOUR
  - SET_HOUR -> SET_MIN
  - SET_MIN -> RUN, clearing seconds and prescaler so the first tick comes TICKS_PER_SEC cycles after exit.
- btn_inc event in RUN: ignored.
- btn_inc event in SET_HOUR: hour increment, with pm toggle on 11 -> 12.
- btn_inc event in SET_MIN: minute increment with no carry; 59 -> 00 and hours are unchanged.
- Simultaneous mode and inc events: mode wins, inc is discarded.
- Blink: on every state entry the counter is 0 and phase is 0 (digits visible). Phase toggles every BLINK_DIV cycles. Any inc event resets the counter and sets phase to 0.
- blink_mask values: {phase,phase,0,0} in SET_HOUR; {0,0,phase,phase} in SET_MIN; 0 in RUN.
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package clk_pkg:
  - state encoding RUN=2'b00, SET_HOUR=2'b01, SET_MIN=2'b10 (2'b11 recovers to RUN)
  - BCD constants for reset time 12:00
  - SEC_MAX=59
- Sub-module bcd12_time_core holds hh:mm, seconds and pm. It takes inc_min_carry, inc_min_nocarry, inc_hour and clr_sec strobes.
- The controller holds the synchronizers, prescaler, FSM and blink logic.

Test Plan (TICKS_PER_SEC=4, BLINK_DIV=3):
1. Assert reset mid-count, release -> digits 1,2,0,0, pm=0, setting=0, blink_mask=0. First sec_tick occurs exactly 4 cycles after release.
2. Run 60*4 cycles from reset -> digits read 12:01. Continue to 12:59 plus 60 ticks -> 01:00, pm=0. Separately, 11:59 AM plus 60 ticks -> 12:00, pm=1.
3. Pulse btn_mode once -> setting=1 at N+3, blink_mask toggles 0000/1100 every 3 cycles. Three btn_inc pulses from 12:00 -> 03:00 and each press forces blink_mask=0000.
4. In SET_MIN at :58, three btn_inc pulses -> :59, :00, :01 with hours unchanged. btn_mode -> RUN, blink_mask=0, next sec_tick 4 cycles later.
5. btn_mode and btn_inc raised in the same cycle while in SET_HOUR -> state SET_MIN, hour unchanged. Holding btn_inc high for 20 cycles gives exactly one increment.
6. Assert reset while in SET_MIN with edited value 07:45 PM -> 12:00 AM, RUN, blink_mask=0 on the cycle after assertion. Outputs are not updated while reset is held.

Source files
------------

// File: rtl/clk_pkg.sv
// clk_pkg: shared definitions for the 12-hour clock time-set controller.
//   - mode state encoding (2'b11 is never entered and recovers to RUN)
//   - BCD reset time 12:00 and the seconds terminal value
//   - packed hh:mm BCD struct passed from the time core to the controller
package clk_pkg;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  localparam logic [3:0] RST_HOUR_TENS = 4'd1;
  localparam logic [3:0] RST_HOUR_ONES = 4'd2;
  localparam logic [3:0] RST_MIN_TENS  = 4'd0;
  localparam logic [3:0] RST_MIN_ONES  = 4'd0;

  localparam logic [5:0] SEC_MAX = 6'd59;

  typedef struct packed {
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
  } bcd_time_t;

  // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> RUN; anything else goes to RUN.
  function automatic logic [1:0] next_mode_state(input logic [1:0] st);
    case (st)
      ST_RUN:      return ST_SET_HOUR;
      ST_SET_HOUR: return ST_SET_MIN;
      default:     return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/bcd12_time_core.sv
// bcd12_time_core: BCD hh:mm, binary seconds and AM/PM flag of a 12-hour clock.
// Ports:
//   clk, reset         clock, asynchronous active-high reset (time 12:00 AM)
//   inc_sec_i          one-second strobe (seconds 0..59 wrap)
//   inc_min_carry_i    minute increment that carries into the hour on 59 -> 00
//   inc_min_nocarry_i  minute increment that wraps 59 -> 00 without touching hours
//   inc_hour_i         hour increment (12 -> 01, 11 -> 12 toggles pm)
//   clr_sec_i          force seconds to 0 (has priority over inc_sec_i)
//   sec_max_o          seconds currently at 59
//   time_o, pm_o       registered time and PM flag
module bcd12_time_core
  import clk_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      inc_sec_i,
  input  logic      inc_min_carry_i,
  input  logic      inc_min_nocarry_i,
  input  logic      inc_hour_i,
  input  logic      clr_sec_i,
  output logic      sec_max_o,
  output bcd_time_t time_o,
  output logic      pm_o
);

  bcd_time_t  time_q, time_d;
  logic [5:0] sec_q, sec_d;
  logic       pm_q, pm_d;
  logic       min_wrap;
  logic       hour_step;

  assign min_wrap  = (time_q.min_tens == 4'd5) && (time_q.min_ones == 4'd9);
  // Only the carrying minute increment may roll over into the hour.
  assign hour_step = inc_hour_i | (inc_min_carry_i & min_wrap);
  assign sec_max_o = (sec_q == SEC_MAX);

  always_comb begin
    time_d = time_q;
    sec_d  = sec_q;
    pm_d   = pm_q;

    if (clr_sec_i) begin
      sec_d = '0;
    end else if (inc_sec_i) begin
      sec_d = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
    end

    if (inc_min_carry_i || inc_min_nocarry_i) begin
      if (time_q.min_ones == 4'd9) begin
        time_d.min_ones = 4'd0;
        time_d.min_tens = min_wrap ? 4'd0 : time_q.min_tens + 4'd1;
      end else begin
        time_d.min_ones = time_q.min_ones + 4'd1;
      end
    end

    if (hour_step) begin
      if (time_q.hour_tens == 4'd1 && time_q.hour_ones == 4'd2) begin
        time_d.hour_tens = 4'd0;
        time_d.hour_ones = 4'd1;
      end else if (time_q.hour_ones == 4'd9) begin
        time_d.hour_tens = 4'd1;
        time_d.hour_ones = 4'd0;
      end else begin
        time_d.hour_ones = time_q.hour_ones + 4'd1;
      end
      // AM/PM flips on the 11 -> 12 step, not on 12 -> 01.
      if (time_q.hour_tens == 4'd1 && time_q.hour_ones == 4'd1) begin
        pm_d = ~pm_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q.hour_tens <= RST_HOUR_TENS;
      time_q.hour_ones <= RST_HOUR_ONES;
      time_q.min_tens  <= RST_MIN_TENS;
      time_q.min_ones  <= RST_MIN_ONES;
      sec_q            <= '0;
      pm_q             <= 1'b0;
    end else begin
      time_q <= time_d;
      sec_q  <= sec_d;
      pm_q   <= pm_d;
    end
  end

  assign time_o = time_q;
  assign pm_o   = pm_q;

endmodule

// File: rtl/clk_time_set_ctrl.sv
// clk_time_set_ctrl: mode controller and time sequencer for a 12-hour clock.
// Ports:
//   clk, reset                   system clock, asynchronous active-high reset
//   btn_mode, btn_inc            debounced buttons, asynchronous to clk
//   digit1_min .. digit4_hour    BCD mm:hh digits (ones of minutes first)
//   pm                           1 = PM
//   setting                      1 while in SET_HOUR or SET_MIN
//   blink_mask                   bit i blanks digit i+1 during set-mode blink
//   sec_tick                     one-cycle pulse per elapsed second in RUN
// All outputs come straight from flops.
module clk_time_set_ctrl
  import clk_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned BLINK_DIV     = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] digit1_min,
  output logic [3:0] digit2_min,
  output logic [3:0] digit3_hour,
  output logic [3:0] digit4_hour,
  output logic       pm,
  output logic       setting,
  output logic [3:0] blink_mask,
  output logic       sec_tick
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Button synchronizers and rising-edge detect; bit 0 = mode, bit 1 = inc.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q, prev_q;
  logic [1:0] btn_ev;
  logic       mode_ev, inc_ev;

  logic [1:0]         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               setting_q;
  logic [3:0]         blink_mask_q, blink_mask_d;
  logic               sec_tick_q;

  logic       in_run;
  logic       tick;
  logic       sec_max;
  bcd_time_t  cur_time;
  logic       cur_pm;

  assign btn_raw = {btn_inc, btn_mode};
  assign btn_ev  = sync2_q & ~prev_q;
  assign mode_ev = btn_ev[0];
  // A mode event in the same cycle swallows any inc event.
  assign inc_ev  = btn_ev[1] & ~mode_ev;

  assign in_run = (state_q == ST_RUN);
  assign tick   = in_run && (presc_q == PRESC_LAST);

  always_comb begin
    if (mode_ev) begin
      state_d = next_mode_state(state_q);
    end else if (state_q == ST_RUN || state_q == ST_SET_HOUR || state_q == ST_SET_MIN) begin
      state_d = state_q;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Prescaler only runs in RUN; held at 0 in set modes so leaving SET_MIN
  // restarts a full second.
  always_comb begin
    presc_d = '0;
    if (in_run) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // Blink restarts visible on every state change and on every accepted inc.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (state_d != ST_RUN && !mode_ev && !inc_ev) begin
      if (blink_cnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        phase_d     = phase_q;
      end
    end
  end

  always_comb begin
    case (state_d)
      ST_SET_HOUR: blink_mask_d = {phase_d, phase_d, 2'b00};
      ST_SET_MIN:  blink_mask_d = {2'b00, phase_d, phase_d};
      default:     blink_mask_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      state_q      <= ST_RUN;
      presc_q      <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      setting_q    <= 1'b0;
      blink_mask_q <= '0;
      sec_tick_q   <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      presc_q      <= presc_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      setting_q    <= (state_d != ST_RUN);
      blink_mask_q <= blink_mask_d;
      sec_tick_q   <= tick;
    end
  end

  bcd12_time_core u_core (
    .clk               (clk),
    .reset             (reset),
    .inc_sec_i         (tick),
    .inc_min_carry_i   (tick & sec_max),
    .inc_min_nocarry_i (inc_ev && (state_q == ST_SET_MIN)),
    .inc_hour_i        (inc_ev && (state_q == ST_SET_HOUR)),
    .clr_sec_i         (~in_run),
    .sec_max_o         (sec_max),
    .time_o            (cur_time),
    .pm_o              (cur_pm)
  );

  assign digit1_min  = cur_time.min_ones;
  assign digit2_min  = cur_time.min_tens;
  assign digit3_hour = cur_time.hour_ones;
  assign digit4_hour = cur_time.hour_tens;
  assign pm          = cur_pm;
  assign setting     = setting_q;
  assign blink_mask  = blink_mask_q;
  assign sec_tick    = sec_tick_q;

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// Bench for clk_time_set_ctrl with TICKS_PER_SEC=4, BLINK_DIV=3. A reference
// model of the clock (hour 1..12, minute, second, mode, blink phase) is advanced
// on every clock edge and compared with all outputs one step after the edge.
module tb_clk_time_set_ctrl;

  localparam int T  = 4;
  localparam int BD = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] digit1_min, digit2_min, digit3_hour, digit4_hour, blink_mask;
  logic       pm, setting, sec_tick;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_hr, m_min, m_sec, m_st, m_presc, m_bcnt;
  bit m_pm, m_ph, m_tick;
  bit hm0, hm1, hm2, hi0, hi1, hi2;
  logic [3:0] ev_mask;

  clk_time_set_ctrl #(.TICKS_PER_SEC(T), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .digit1_min  (digit1_min),
    .digit2_min  (digit2_min),
    .digit3_hour (digit3_hour),
    .digit4_hour (digit4_hour),
    .pm          (pm),
    .setting     (setting),
    .blink_mask  (blink_mask),
    .sec_tick    (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hr = 12; m_min = 0; m_sec = 0; m_pm = 0;
    m_st = 0; m_presc = 0; m_bcnt = 0; m_ph = 0; m_tick = 0;
    hm0 = 0; hm1 = 0; hm2 = 0; hi0 = 0; hi1 = 0; hi2 = 0;
  endtask

  task automatic hour_inc();
    if (m_hr == 11) begin m_hr = 12; m_pm = !m_pm; end
    else if (m_hr == 12) m_hr = 1;
    else m_hr = m_hr + 1;
  endtask

  // A button level seen at edge k becomes an event applied at edge k+2.
  task automatic model_edge();
    bit mode_ev, inc_ev, tk;
    int nst;
    mode_ev = hm1 && !hm2;
    inc_ev  = hi1 && !hi2 && !mode_ev;
    hm2 = hm1; hm1 = hm0; hm0 = btn_mode;
    hi2 = hi1; hi1 = hi0; hi0 = btn_inc;
    tk = (m_st == 0) && (m_presc == T - 1);
    m_presc = (m_st == 0) ? (m_presc + 1) % T : 0;
    if (m_st == 0) begin
      if (tk) begin
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min++;
          if (m_min == 60) begin m_min = 0; hour_inc(); end
        end
      end
    end else begin
      m_sec = 0;
    end
    if (inc_ev && m_st == 1) hour_inc();
    if (inc_ev && m_st == 2) m_min = (m_min + 1) % 60;
    nst = mode_ev ? (m_st + 1) % 3 : m_st;
    if (nst == 0 || mode_ev || inc_ev) begin m_bcnt = 0; m_ph = 0; end
    else if (m_bcnt == BD - 1) begin m_bcnt = 0; m_ph = !m_ph; end
    else m_bcnt++;
    m_st = nst;
    m_tick = tk;
  endtask

  function automatic logic [15:0] model_digits();
    return {4'(m_hr / 10), 4'(m_hr % 10), 4'(m_min / 10), 4'(m_min % 10)};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {digit4_hour, digit3_hour, digit2_min, digit1_min};
  endfunction

  task automatic check_outputs();
    logic [3:0] em;
    em = 4'b0000;
    if (m_st == 1 && m_ph) em = 4'b1100;
    if (m_st == 2 && m_ph) em = 4'b0011;
    chk("digits", dut_digits(), model_digits());
    chk("pm", 16'(pm), 16'(m_pm));
    chk("setting", 16'(setting), 16'(m_st != 0));
    chk("blink_mask", 16'(blink_mask), 16'(em));
    chk("sec_tick", 16'(sec_tick), 16'(m_tick));
  endtask

  task automatic tick_clk();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
    check_outputs();
  endtask

  // Press a button for 3 cycles; the event lands on the third edge.
  task automatic press(input bit is_mode);
    if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
    repeat (3) tick_clk();
    ev_mask = blink_mask;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (2) tick_clk();
    $display("press %s -> %0d%0d:%0d%0d pm=%0b setting=%0b", is_mode ? "mode" : "inc ",
             digit4_hour, digit3_hour, digit2_min, digit1_min, pm, setting);
  endtask

  initial begin
    int n;
    int guard;
    model_reset();

    // 1. reset state, reset mid-count, first tick latency
    repeat (3) tick_clk();
    reset = 1'b0;
    repeat (2) tick_clk();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_async_digits", dut_digits(), 16'h1200);
    chk("rst_async_mask", 16'(blink_mask), 16'h0);
    chk("rst_async_setting", 16'(setting), 16'h0);
    repeat (2) tick_clk();
    reset = 1'b0;
    n = 0;
    do begin tick_clk(); n++; end while (!sec_tick && n < 8);
    chk("first_tick_lat", 16'(n), 16'd4);
    $display("step1 reset/first tick after %0d cycles", n);

    // 2. minute/hour rollovers in RUN
    repeat (236) tick_clk();
    chk("run_1201", dut_digits(), 16'h1201);
    press(1); press(1);
    guard = 0;
    while (m_min != 59 && guard < 70) begin press(0); guard++; end
    chk("reach_1259", dut_digits(), 16'h1259);
    press(1);
    repeat (238) tick_clk();
    chk("run_0100", dut_digits(), 16'h0100);
    chk("run_0100_pm", 16'(pm), 16'h0);
    press(1);
    guard = 0;
    while (m_hr != 11 && guard < 20) begin press(0); guard++; end
    press(1);
    guard = 0;
    while (m_min != 59 && guard < 70) begin press(0); guard++; end
    chk("reach_1159", dut_digits(), 16'h1159);
    press(1);
    repeat (238) tick_clk();
    chk("run_1200pm", dut_digits(), 16'h1200);
    chk("run_1200pm_pm", 16'(pm), 16'h1);

    // 3. enter SET_HOUR: setting at N+3, blink, hour presses
    btn_mode = 1'b1;
    tick_clk(); tick_clk();
    chk("setting_n2", 16'(setting), 16'h0);
    tick_clk();
    chk("setting_n3", 16'(setting), 16'h1);
    btn_mode = 1'b0;
    repeat (2) tick_clk();
    tick_clk();
    chk("blink_on_hour", 16'(blink_mask), 16'hc);
    repeat (3) begin
      press(0);
      chk("inc_blank", 16'(ev_mask), 16'h0);
    end
    chk("set_0300", dut_digits(), 16'h0300);
    chk("set_0300_pm", 16'(pm), 16'h1);

    // 4. SET_MIN wrap without carry, then exit timing
    press(1);
    guard = 0;
    while (m_min != 58 && guard < 70) begin press(0); guard++; end
    press(0); chk("min_59", dut_digits(), 16'h0359);
    press(0); chk("min_00", dut_digits(), 16'h0300);
    press(0); chk("min_01", dut_digits(), 16'h0301);
    btn_mode = 1'b1;
    repeat (3) tick_clk();
    btn_mode = 1'b0;
    chk("exit_mask", 16'(blink_mask), 16'h0);
    chk("exit_setting", 16'(setting), 16'h0);
    n = 0;
    do begin tick_clk(); n++; end while (!sec_tick && n < 8);
    chk("exit_tick_lat", 16'(n), 16'd4);
    $display("step4 exit SET_MIN, first tick after %0d cycles", n);

    // 5. simultaneous mode+inc in SET_HOUR, held inc
    press(1);
    btn_mode = 1'b1; btn_inc = 1'b1;
    repeat (3) tick_clk();
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) tick_clk();
    chk("both_in_set_min", 16'(blink_mask), 16'h3);
    chk("both_hour_same", 16'({digit4_hour, digit3_hour}), 16'h03);
    btn_inc = 1'b1;
    repeat (20) tick_clk();
    btn_inc = 1'b0;
    repeat (2) tick_clk();
    chk("held_inc_once", 16'({digit2_min, digit1_min}), 16'h02);
    $display("step5 simultaneous/held -> %0d%0d:%0d%0d", digit4_hour, digit3_hour, digit2_min, digit1_min);

    // random button traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 3) == 0) btn_inc = ~btn_inc;
      tick_clk();
    end
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (4) tick_clk();
    $display("random phase done, checks so far %0d", checks);

    // 6. reset while editing 07:45 PM in SET_MIN
    guard = 0;
    while (m_st != 1 && guard < 4) begin press(1); guard++; end
    guard = 0;
    while (!(m_hr == 7 && m_pm) && guard < 30) begin press(0); guard++; end
    press(1);
    guard = 0;
    while (m_min != 45 && guard < 70) begin press(0); guard++; end
    chk("reach_0745", dut_digits(), 16'h0745);
    chk("reach_0745_pm", 16'(pm), 16'h1);
    chk("reach_set_min", 16'(m_st), 16'd2);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_edit_digits", dut_digits(), 16'h1200);
    chk("rst_edit_pm", 16'(pm), 16'h0);
    chk("rst_edit_setting", 16'(setting), 16'h0);
    chk("rst_edit_mask", 16'(blink_mask), 16'h0);
    btn_inc = 1'b1;
    repeat (5) tick_clk();
    btn_inc = 1'b0;
    reset = 1'b0;
    repeat (10) tick_clk();
    $display("step6 reset during edit -> %0d%0d:%0d%0d pm=%0b", digit4_hour, digit3_hour, digit2_min, digit1_min, pm);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
